prewitt_frame_ctrl: RTL and testbench

Streaming frame sequencer for the Prewitt edge kernel. It accepts a raster-order pixel stream through a valid/ready handshake and keeps two line buffers plus a 3x3 window. It drives the combinational kernel, forces border pixels to zero, and emits one output pixel per input pixel in raster order. It replaces the file-based batch flow: upstream is an image loader, downstream is an image writer.

---
 rtl/prewitt_pkg.sv | 28 ++
 rtl/prewitt_kernel.sv | 41 ++++
 rtl/prewitt_frame_ctrl.sv | 151 +++++++++++++++
 tb/tb_prewitt_frame_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/prewitt_pkg.sv
// Shared types and the Prewitt combine/clamp/saturate helper for the frame controller.
package prewitt_pkg;

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;

  localparam int PIX_W_DEF = 8;

  // abs_en selects |gx|+|gy|; otherwise negative gradients are clamped to 0.
  function automatic logic [31:0] prewitt_combine(input logic signed [31:0] gx,
                                                  input logic signed [31:0] gy,
                                                  input logic               abs_en,
                                                  input logic        [31:0] max_val);
    logic signed [31:0] ax;
    logic signed [31:0] ay;
    logic signed [31:0] sum;
    if (abs_en) begin
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
    end else begin
      ax = (gx < 0) ? 32'sd0 : gx;
      ay = (gy < 0) ? 32'sd0 : gy;
    end
    sum = ax + ay;
    if (sum > $signed(max_val)) return max_val;
    return sum;
  endfunction

endpackage

// File: rtl/prewitt_kernel.sv
// Combinational 3x3 Prewitt kernel; PREWITT_ABS_EN selects |gx|+|gy| instead of clamped gx+gy.
module prewitt_kernel
  import prewitt_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic [PIX_W-1:0] win [9],
  output logic [PIX_W-1:0] pix
);

  localparam int SW = PIX_W + 4;
  localparam logic [31:0] MAX_VAL = 32'((64'd1 << PIX_W) - 64'd1);

`ifdef PREWITT_ABS_EN
  localparam logic ABS_EN = 1'b1;
`else
  localparam logic ABS_EN = 1'b0;
`endif

  function automatic logic signed [SW-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({4'b0000, p});
  endfunction

  logic signed [SW-1:0] top, bot, lft, rgt, gx, gy;

  always_comb begin
    top = ext(win[0]) + ext(win[1]) + ext(win[2]);
    bot = ext(win[6]) + ext(win[7]) + ext(win[8]);
    lft = ext(win[0]) + ext(win[3]) + ext(win[6]);
    rgt = ext(win[2]) + ext(win[5]) + ext(win[8]);
    gx  = top - bot;
    gy  = lft - rgt;
  end

  assign pix = PIX_W'(prewitt_combine(32'(gx), 32'(gy), ABS_EN, MAX_VAL));

  // The Prewitt operator has a zero centre tap.
  logic unused_center;
  assign unused_center = ^win[4];

endmodule

// File: rtl/prewitt_frame_ctrl.sv
// Streaming Prewitt frame sequencer: two line buffers, 3x3 window, border zeroing, one output per input.
// Build option: PREWITT_ABS_EN (honoured inside prewitt_kernel).
module prewitt_frame_ctrl
  import prewitt_pkg::*;
#(
  parameter int ROWS  = 256,
  parameter int COLS  = 256,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PIX_W-1:0] s_pixel,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [PIX_W-1:0] m_pixel,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             busy,
  output logic             done
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  state_t state, state_nxt;

  logic [RW-1:0] in_row, out_row;
  logic [CW-1:0] in_col, out_col;

  logic [PIX_W-1:0] line_a [COLS];
  logic [PIX_W-1:0] line_b [COLS];
  logic [PIX_W-1:0] win    [9];
  logic [PIX_W-1:0] win_d  [9];
  logic [PIX_W-1:0] kpix;

  logic s_hs, m_hs, border, out_wrapped, run_load, flush_load, load, done_d;

  assign s_hs        = s_valid && s_ready;
  assign m_hs        = m_valid && m_ready;
  assign busy        = (state != IDLE);
  assign border      = (out_row == '0) || (out_row == LAST_ROW) ||
                       (out_col == '0) || (out_col == LAST_COL);
  // Out counters wrap to (0,0) once the final pixel has been loaded.
  assign out_wrapped = (out_row == '0) && (out_col == '0);
  assign run_load    = (state == RUN) && s_hs;
  assign flush_load  = (state == FLUSH) && (!m_valid || m_ready) && !out_wrapped;
  assign load        = run_load || flush_load;
  assign done_d      = (state == FLUSH) && m_hs && out_wrapped;

  always_comb begin
    s_ready = 1'b0;
    case (state)
      FILL:    s_ready = 1'b1;
      RUN:     s_ready = !m_valid || m_ready;
      default: s_ready = 1'b0;
    endcase
  end

  // Window as it will look after this handshake; the kernel sees it directly.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_d[3*r]   = win[3*r+1];
      win_d[3*r+1] = win[3*r+2];
    end
    win_d[2] = line_a[in_col];
    win_d[5] = line_b[in_col];
    win_d[8] = s_pixel;
  end

  prewitt_kernel #(.PIX_W(PIX_W)) u_kernel (
    .win (win_d),
    .pix (kpix)
  );

  always_ff @(posedge clk) begin
    if (s_hs) begin
      win            <= win_d;
      line_a[in_col] <= line_b[in_col];
      line_b[in_col] <= s_pixel;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = FILL;
      FILL:  if (s_hs && in_row == RW'(1) && in_col == '0) state_nxt = RUN;
      RUN:   if (s_hs && in_row == LAST_ROW && in_col == LAST_COL) state_nxt = FLUSH;
      FLUSH: if (done_d) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_row  <= '0;
      in_col  <= '0;
      out_row <= '0;
      out_col <= '0;
    end else if (state == IDLE && start) begin
      in_row  <= '0;
      in_col  <= '0;
      out_row <= '0;
      out_col <= '0;
    end else begin
      if (s_hs) begin
        if (in_col == LAST_COL) begin
          in_col <= '0;
          in_row <= (in_row == LAST_ROW) ? '0 : in_row + 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end
      end
      if (load) begin
        if (out_col == LAST_COL) begin
          out_col <= '0;
          out_row <= (out_row == LAST_ROW) ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end
    end
  end

  // Output stage: single register, holds until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_pixel <= '0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_pixel <= (run_load && !border) ? kpix : '0;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prewitt_frame_ctrl.sv
// Directed bench for prewitt_frame_ctrl on a 4x5 frame with hand-computed expected outputs.
module tb_prewitt_frame_ctrl;

  typedef logic [7:0] frame_t [20];

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] s_pixel;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_pixel;
  logic       m_valid;
  logic       m_ready;
  logic       busy;
  logic       done;

  int vectors;
  int miscompares;

  prewitt_frame_ctrl #(.ROWS(4), .COLS(5), .PIX_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .s_pixel (s_pixel),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_pixel (m_pixel),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .busy    (busy),
    .done    (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input string name, input frame_t img, input frame_t expv,
                           input int stall_at, input int stall_len);
    int in_idx = 0;
    int out_idx = 0;
    int dones = 0;
    int cyc = 0;
    int post = 0;
    logic sh, mh, held_v, done_seen, prev_busy;
    logic [7:0] held_px;
    held_v = 1'b0;
    held_px = 8'h00;
    done_seen = 1'b0;
    prev_busy = 1'b0;
    pulse_start();
    while (cyc < 120 && post < 4) begin
      s_valid = (in_idx < 20);
      s_pixel = (in_idx < 20) ? img[in_idx] : 8'h00;
      m_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
      @(negedge clk);
      sh = s_valid && s_ready;
      mh = m_valid && m_ready;
      if (held_v) chk($sformatf("%s_hold_c%0d", name, cyc), m_pixel, held_px);
      if (m_valid && !m_ready) begin
        chk($sformatf("%s_sready_stall_c%0d", name, cyc), s_ready, 0);
        held_v = 1'b1;
        held_px = m_pixel;
      end else begin
        held_v = 1'b0;
      end
      if (mh) begin
        if (out_idx < 20) chk($sformatf("%s_px%0d", name, out_idx), m_pixel, expv[out_idx]);
        out_idx++;
      end
      if (done) begin
        dones++;
        chk({name, "_busy_at_done"}, busy, 0);
        chk({name, "_busy_before_done"}, prev_busy, 1);
        chk({name, "_outs_at_done"}, out_idx, 20);
        done_seen = 1'b1;
      end
      prev_busy = busy;
      if (done_seen) post++;
      @(posedge clk); #1;
      if (sh) in_idx++;
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    chk({name, "_done_count"}, dones, 1);
    chk({name, "_out_count"}, out_idx, 20);
    chk({name, "_in_count"}, in_idx, 20);
  endtask

  initial begin
    frame_t img_uni, img_step, img_inv, img_sat;
    frame_t exp_zero, exp_step, exp_sat, exp_inv;
    int cnt;
    logic sh;

    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    start = 1'b0;
    s_valid = 1'b0;
    s_pixel = 8'h00;
    m_ready = 1'b1;

    img_uni  = '{default: 8'd100};
    exp_zero = '{default: 8'd0};
    img_step = '{30,30,0,0,0, 30,30,0,0,0, 30,30,0,0,0, 30,30,0,0,0};
    img_inv  = '{0,0,30,30,30, 0,0,30,30,30, 0,0,30,30,30, 0,0,30,30,30};
    img_sat  = '{200,200,0,0,0, 200,200,0,0,0, 200,200,0,0,0, 200,200,0,0,0};
    exp_step = '{0,0,0,0,0, 0,90,90,0,0, 0,90,90,0,0, 0,0,0,0,0};
    exp_sat  = '{0,0,0,0,0, 0,255,255,0,0, 0,255,255,0,0, 0,0,0,0,0};
`ifdef PREWITT_ABS_EN
    exp_inv = exp_step;
`else
    exp_inv = exp_zero;
`endif

    @(negedge clk);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_pixel", m_pixel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    #2 rst_n = 1'b1;

    run_frame("uni", img_uni, exp_zero, 1000, 0);
    run_frame("step", img_step, exp_step, 1000, 0);
    run_frame("inv", img_inv, exp_inv, 1000, 0);
    run_frame("sat", img_sat, exp_sat, 1000, 0);
    run_frame("stall", img_step, exp_step, 10, 10);

    // Abort a frame with reset after 8 accepted inputs.
    pulse_start();
    m_ready = 1'b1;
    s_valid = 1'b1;
    cnt = 0;
    for (int c = 0; c < 40 && cnt < 8; c++) begin
      s_pixel = img_step[cnt];
      @(negedge clk);
      sh = s_valid && s_ready;
      @(posedge clk); #1;
      if (sh) cnt++;
    end
    chk("abort_inputs", cnt, 8);
    chk("abort_pre_mvalid", m_valid, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_m_valid", m_valid, 0);
    chk("abort_s_ready", s_ready, 0);
    chk("abort_busy", busy, 0);
    chk("abort_m_pixel", m_pixel, 0);
    s_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("abort_done_c%0d", c), done, 0);
    end
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle_busy", busy, 0);
    chk("abort_idle_done", done, 0);

    run_frame("after", img_step, exp_step, 1000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
